// File: rtl/board_link_rx_pkg.sv
// Shared definitions for both ends of the inter-board sudoku link.
package board_link_rx_pkg;

    localparam int LINK_WORDS = 82;
    localparam int GRID_CELLS = 81;

    typedef logic [3:0] word_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAITV = 3'd2,
        ACK   = 3'd3,
        CLOSE = 3'd4,
        ABORT = 3'd5
    } state_t;

endpackage

// File: rtl/board_link_rx_sync_nff.sv
// Multi-flop synchroniser for asynchronous peer inputs; width and depth are parameters.
module sync_nff #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [STAGES-1:0][WIDTH-1:0] r_stage;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage <= '0;
        end else begin
            r_stage <= {r_stage[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/board_link_rx.sv
// Receiving end of the sudoku board link: requests a transfer, then takes one
// header word and 81 cell words from the peer, writing cells to the local grid.
module board_link_rx
    import board_link_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       request,
    input  logic       ack_in,
    input  logic       valid,
    input  logic [3:0] data,
    output logic       ack_out,
    output logic [3:0] header,
    output logic       wr_en,
    output logic [6:0] wr_addr,
    output logic [3:0] wr_data,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [2:0] dbg_state
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    // Four-phase handshake: peer raises valid with stable data, we capture and
    // raise ack_out, peer drops valid, we drop ack_out and move to the next word.
    logic       w_ack_s;
    logic       w_valid_s;
    word_t      w_data_s;

    sync_nff #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_ack (
        .clk (clk), .rst (rst), .i_d (ack_in), .o_q (w_ack_s)
    );
    sync_nff #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_valid (
        .clk (clk), .rst (rst), .i_d (valid), .o_q (w_valid_s)
    );
    sync_nff #(.WIDTH(4), .STAGES(SYNC_STAGES)) u_sync_data (
        .clk (clk), .rst (rst), .i_d (data), .o_q (w_data_s)
    );

    state_t     r_state;
    state_t     w_next;
    logic [6:0] r_idx;
    logic [TMO_W-1:0] r_tmo;
    word_t      r_header;
    logic       r_wr_en;
    logic [6:0] r_wr_addr;
    word_t      r_wr_data;
    logic       r_done;
    logic       r_error;

    logic       w_tmo_hit;
    logic       w_capture;
    logic       w_advance;
    logic       w_finish;
    logic       w_abort;
    logic       w_timed;

    assign w_timed   = (r_state == REQ) || (r_state == WAITV) ||
                       (r_state == ACK) || (r_state == CLOSE);
    assign w_tmo_hit = w_timed && (r_tmo == TMO_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_advance = 1'b0;
        w_finish  = 1'b0;
        w_abort   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next = REQ;
            end
            REQ: begin
                if (w_tmo_hit)    w_abort = 1'b1;
                else if (w_ack_s) w_next  = WAITV;
            end
            WAITV: begin
                if (w_tmo_hit) begin
                    w_abort = 1'b1;
                end else if (w_valid_s) begin
                    w_capture = 1'b1;
                    w_next    = ACK;
                end
            end
            ACK: begin
                if (w_tmo_hit) begin
                    w_abort = 1'b1;
                end else if (!w_valid_s) begin
                    w_advance = 1'b1;
                    w_next    = (r_idx == 7'(LINK_WORDS - 1)) ? CLOSE : WAITV;
                end
            end
            CLOSE: begin
                if (w_tmo_hit) begin
                    w_abort = 1'b1;
                end else if (!w_ack_s) begin
                    w_finish = 1'b1;
                    w_next   = IDLE;
                end
            end
            ABORT: begin
                if (!w_ack_s && !w_valid_s) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (w_abort) w_next = ABORT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx     <= '0;
            r_tmo     <= '0;
            r_header  <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            if (w_next != r_state || !w_timed) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + 1'b1;
            end

            // idx saturates at the last word so wr_addr can never exceed 80.
            if (r_state == IDLE && start) begin
                r_idx <= '0;
            end else if (w_advance && r_idx != 7'(LINK_WORDS - 1)) begin
                r_idx <= r_idx + 7'd1;
            end

            if (w_capture && r_idx == 7'd0) begin
                r_header <= w_data_s;
            end

            r_wr_en   <= w_capture && (r_idx != 7'd0);
            r_wr_addr <= (w_capture && r_idx != 7'd0) ? r_idx - 7'd1 : 7'd0;
            r_wr_data <= (w_capture && r_idx != 7'd0) ? w_data_s : 4'd0;
            r_done    <= w_finish;
            r_error   <= w_abort;
        end
    end

    assign request   = (r_state == REQ) || (r_state == WAITV) || (r_state == ACK);
    assign ack_out   = (r_state == ACK);
    assign busy      = (r_state != IDLE);
    assign header    = r_header;
    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign done      = r_done;
    assign error     = r_error;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_board_link_rx.sv
// Bench for board_link_rx: acts as the peer board and scoreboards grid writes.
module tb_board_link_rx;
    import board_link_rx_pkg::*;

    localparam int SYNC = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, ack_in, valid;
    logic [3:0] data;
    logic       request, ack_out, wr_en, busy, done, error;
    logic [3:0] header, wr_data;
    logic [6:0] wr_addr;
    logic [2:0] dbg_state;

    logic       start2, ack_in2, valid2;
    logic [3:0] data2;
    logic       request2, ack_out2, wr_en2, busy2, done2, error2;
    logic [3:0] header2, wr_data2;
    logic [6:0] wr_addr2;
    logic [2:0] dbg_state2;

    board_link_rx #(.SYNC_STAGES(SYNC), .TIMEOUT(1000)) dut (
        .clk(clk), .rst(rst), .start(start), .request(request),
        .ack_in(ack_in), .valid(valid), .data(data), .ack_out(ack_out),
        .header(header), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .error(error), .dbg_state(dbg_state)
    );

    board_link_rx #(.SYNC_STAGES(SYNC), .TIMEOUT(16)) dut_t (
        .clk(clk), .rst(rst), .start(start2), .request(request2),
        .ack_in(ack_in2), .valid(valid2), .data(data2), .ack_out(ack_out2),
        .header(header2), .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
        .busy(busy2), .done(done2), .error(error2), .dbg_state(dbg_state2)
    );

    int checks = 0;
    int failures = 0;
    int wr_cnt = 0, done_cnt = 0, err_cnt = 0, wr_cnt2 = 0, err_cnt2 = 0;
    logic [10:0] exp_q[$];
    logic [10:0] exp_w;
    logic [3:0]  cells[81];

    // Scoreboard: every grid write must match the head of the expected queue.
    always @(negedge clk) begin
        if (wr_en) begin
            wr_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL wr_unexpected: got addr=%0d data=%0d, required no write", wr_addr, wr_data);
            end else begin
                exp_w = exp_q.pop_front();
                if ({wr_addr, wr_data} !== exp_w) begin
                    failures++;
                    $display("FAIL wr_cell: got addr=%0d data=%0d, required addr=%0d data=%0d",
                             wr_addr, wr_data, exp_w[10:4], exp_w[3:0]);
                end
            end
        end
        if (done)   done_cnt++;
        if (error)  err_cnt++;
        if (wr_en2) wr_cnt2++;
        if (error2) err_cnt2++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    function automatic logic sig(input int sel);
        case (sel)
            0:       return request;
            1:       return ack_out;
            2:       return busy;
            3:       return request2;
            default: return busy2;
        endcase
    endfunction

    task automatic wait_sig(input int sel, input logic lvl, input int budget, input string name);
        int n = 0;
        while (sig(sel) !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sig(sel) !== lvl) begin
            checks++;
            failures++;
            $display("FAIL %s: level still %0b after %0d cycles, required %0b", name, sig(sel), budget, lvl);
        end
    endtask

    task automatic clear_counts();
        wr_cnt = 0; done_cnt = 0; err_cnt = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_word(input logic [3:0] d, input int stall, input int hold);
        data = d;
        repeat (SYNC + 1) @(negedge clk);
        valid = 1'b1;
        wait_sig(1, 1'b1, 40, "ack_rise");
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            checks++;
            if (ack_out !== 1'b1) begin
                failures++;
                $display("FAIL ack_held: got ack_out=%0b, required 1 while valid high", ack_out);
            end
        end
        valid = 1'b0;
        wait_sig(1, 1'b0, 40, "ack_fall");
        repeat (stall) @(negedge clk);
    endtask

    task automatic peer_transfer(input logic [3:0] hdr, input int stall, input int hold_word,
                                 input int poke_word, input int last_word);
        logic [3:0] d;
        int n;
        wait_sig(0, 1'b1, 20, "req_rise");
        ack_in = 1'b1;
        for (int w = 0; w <= last_word; w++) begin
            d = (w == 0) ? hdr : cells[w-1];
            if (w > 0) exp_q.push_back({7'(w - 1), d});
            if (w == poke_word) pulse_start();
            send_word(d, stall, (w == hold_word) ? 50 : 0);
        end
        if (last_word == 81) begin
            wait_sig(0, 1'b0, 20, "req_fall");
            ack_in = 1'b0;
            n = 0;
            while (done !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (done !== 1'b1) begin
                checks++;
                failures++;
                $display("FAIL done_wait: done=%0b after %0d cycles, required 1", done, n);
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_complete(input string name, input logic [3:0] hdr);
        checks++;
        if (wr_cnt !== 81) begin failures++; $display("FAIL %s_wr_count: got %0d, required 81", name, wr_cnt); end
        checks++;
        if (done_cnt !== 1) begin failures++; $display("FAIL %s_done_count: got %0d, required 1", name, done_cnt); end
        checks++;
        if (header !== hdr) begin failures++; $display("FAIL %s_header: got %0h, required %0h", name, header, hdr); end
        checks++;
        if (request !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle: got request=%0b busy=%0b, required 0 0", name, request, busy);
        end
        checks++;
        if (exp_q.size() !== 0) begin failures++; $display("FAIL %s_queue: %0d writes missing, required 0", name, exp_q.size()); end
        checks++;
        if (err_cnt !== 0) begin failures++; $display("FAIL %s_error: got %0d error pulses, required 0", name, err_cnt); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({request, ack_out, busy, done, error, wr_en} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctl: got %b, required 000000", {request, ack_out, busy, done, error, wr_en});
        end
        checks++;
        if ({header, wr_addr, wr_data, dbg_state} !== 18'b0) begin
            failures++;
            $display("FAIL reset_data: got hdr=%0h addr=%0d data=%0h state=%0d, required all 0",
                     header, wr_addr, wr_data, dbg_state);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL start_during_reset: got busy=%0b, required 0", busy); end
    endtask

    task automatic test_full_transfer();
        for (int i = 0; i < 81; i++) cells[i] = 4'(i % 10);
        clear_counts();
        pulse_start();
        checks++;
        if (request !== 1'b1) begin failures++; $display("FAIL req_latency: got request=%0b, required 1", request); end
        peer_transfer(4'h1, 0, -1, -1, 81);
        check_complete("full", 4'h1);
    endtask

    task automatic test_no_ack();
        int n = 0;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        wait_sig(3, 1'b1, 5, "t_req_rise");
        while (error2 !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n < 15 || n > 17) begin failures++; $display("FAIL timeout_latency: got %0d cycles, required 15..17", n); end
        checks++;
        if (request2 !== 1'b0) begin failures++; $display("FAIL timeout_req: got request=%0b, required 0", request2); end
        repeat (4) @(negedge clk);
        checks++;
        if (busy2 !== 1'b0 || err_cnt2 !== 1) begin
            failures++;
            $display("FAIL timeout_idle: got busy=%0b errors=%0d, required 0 1", busy2, err_cnt2);
        end
        checks++;
        if (wr_cnt2 !== 0) begin failures++; $display("FAIL timeout_wr: got %0d writes, required 0", wr_cnt2); end
    endtask

    task automatic test_hold_valid();
        for (int i = 0; i < 81; i++) cells[i] = 4'($urandom_range(0, 15));
        clear_counts();
        pulse_start();
        peer_transfer(4'hA, 0, 5, -1, 81);
        check_complete("hold", 4'hA);
    endtask

    task automatic test_start_mid();
        for (int i = 0; i < 81; i++) cells[i] = 4'($urandom_range(0, 9));
        clear_counts();
        pulse_start();
        peer_transfer(4'h3, 0, -1, 30, 81);
        check_complete("restart", 4'h3);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 81; i++) cells[i] = 4'($urandom_range(0, 15));
        clear_counts();
        pulse_start();
        peer_transfer(4'h5, 0, -1, -1, 40);
        checks++;
        if (wr_cnt !== 40) begin failures++; $display("FAIL mid_wr_count: got %0d, required 40", wr_cnt); end
        rst = 1'b1;
        ack_in = 1'b0;
        @(negedge clk);
        checks++;
        if ({request, ack_out, busy} !== 3'b0) begin
            failures++;
            $display("FAIL mid_reset: got req=%0b ack=%0b busy=%0b, required 0 0 0", request, ack_out, busy);
        end
        rst = 1'b0;
        exp_q.delete();
        repeat (4) @(negedge clk);
        for (int i = 0; i < 81; i++) cells[i] = 4'($urandom_range(0, 15));
        clear_counts();
        pulse_start();
        peer_transfer(4'h7, 0, -1, -1, 81);
        check_complete("after_reset", 4'h7);
    endtask

    task automatic test_stall();
        for (int i = 0; i < 81; i++) cells[i] = 4'(80 - i);
        clear_counts();
        pulse_start();
        peer_transfer(4'h9, 100, -1, -1, 81);
        check_complete("stall", 4'h9);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ack_in = 1'b0; valid = 1'b0; data = 4'h0;
        start2 = 1'b0; ack_in2 = 1'b0; valid2 = 1'b0; data2 = 4'h0;
        @(negedge clk);
        test_reset();
        test_full_transfer();
        test_no_ack();
        test_hold_valid();
        test_start_mid();
        test_reset_mid();
        test_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
